// File: rtl/seq_serializer_pkg.sv
// Shared definitions for the serializer slice: shifter states and line defaults.
package seq_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic IDLE_BIT_DEFAULT = 1'b0;

endpackage

// File: rtl/seq_serializer_if.sv
// Host-side word handshake into the serializer.
interface seq_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/seq_serializer_sync_fifo.sv
// Single-clock FIFO with occupancy count; push ignored when full, pop ignored when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/seq_serializer.sv
// Buffers host words in a FIFO and shifts them out one bit per clock on 'a',
// chaining words back-to-back while data remains.
module seq_serializer
    import seq_serializer_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter int   DEPTH     = 4,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    seq_serializer_if.slave        host,
    output logic                   a,
    output logic                   a_valid,
    output logic                   frame_start,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);
    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] head;
    logic [CW-1:0]    bit_cnt;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             load_bit;
    logic             adv_bit;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (host.in_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    assign host.in_ready = ~full;
    assign push          = host.in_valid & ~full;
    // Pop only on a word boundary; 'empty' is registered, so a same-edge push is never bypassed.
    assign pop           = ~empty & ((state == ST_IDLE) | (bit_cnt == LAST));
    assign busy          = (state == ST_SHIFT) | ~empty;

    always_comb begin
        shifted  = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
        load_bit = MSB_FIRST ? head[WIDTH-1] : head[0];
        adv_bit  = MSB_FIRST ? sreg[WIDTH-2] : sreg[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            sreg        <= '0;
            bit_cnt     <= '0;
            a           <= IDLE_BIT;
            a_valid     <= 1'b0;
            frame_start <= 1'b0;
        end else if (pop) begin
            state       <= ST_SHIFT;
            sreg        <= head;
            bit_cnt     <= '0;
            a           <= load_bit;
            a_valid     <= 1'b1;
            frame_start <= 1'b1;
        end else if (state == ST_SHIFT && bit_cnt != LAST) begin
            sreg        <= shifted;
            bit_cnt     <= bit_cnt + CW'(1);
            a           <= adv_bit;
            a_valid     <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            state       <= ST_IDLE;
            a           <= IDLE_BIT;
            a_valid     <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule
